// File: rtl/entrada_numero_pkg.sv
// Shared definitions for the keypad number-entry block.
// Holds the key code constants the scanner emits and the state
// encodings of both FSMs (press filter and BCD accumulator).
package teclado_pkg;

  localparam logic [3:0] K_NONE  = 4'hF;  // no key; '#' also maps here
  localparam logic [3:0] K_STAR  = 4'hE;  // clear
  localparam logic [3:0] K_ENTER = 4'hD;  // commit number
  localparam logic [3:0] K_BACK  = 4'hA;  // backspace (optional feature)

  typedef enum logic [1:0] {
    REPOSO,
    CANDIDATO,
    PRESIONADO
  } filtro_estado_t;

  typedef enum logic {
    EDITANDO,
    ENTREGANDO
  } acum_estado_t;

endpackage

// File: rtl/entrada_numero_if.sv
// Number delivery channel: BCD value plus digit count, offered on a
// valid/ready handshake.
//   numero       : BCD value, least significant digit in [3:0]
//   n_digitos    : digits currently entered
//   numero_valid : numero is committed and waiting for the consumer
//   numero_ready : consumer accepts numero
// master = producer (entrada_numero), slave = consumer.
interface entrada_numero_if #(
  parameter int N_DIGITS = 3
);
  localparam int NW = $clog2(N_DIGITS + 1);

  logic [4*N_DIGITS-1:0] numero;
  logic [NW-1:0]         n_digitos;
  logic                  numero_valid;
  logic                  numero_ready;

  modport master (output numero, output n_digitos, output numero_valid,
                  input  numero_ready);
  modport slave  (input  numero, input  n_digitos, input  numero_valid,
                  output numero_ready);
endinterface

// File: rtl/entrada_numero_antirrebote_tecla.sv
// Press filter: turns the intermittent scanner code into one clean
// event per physical press, with debounce and release detection.
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   boton         : scanner code, 0xF = none
//   tecla_evento  : one-cycle pulse per accepted press
//   tecla_codigo  : code of last accepted press (0xF after reset)
module antirrebote_tecla
  import teclado_pkg::*;
#(
  parameter int DEBOUNCE_CYC = 1000,
  parameter int RELEASE_CYC  = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] boton,
  output logic       tecla_evento,
  output logic [3:0] tecla_codigo
);

  localparam int HW = $clog2(DEBOUNCE_CYC + 1);
  localparam int GW = $clog2(RELEASE_CYC + 1);
  localparam logic [HW-1:0] HMAX = HW'(DEBOUNCE_CYC);
  localparam logic [HW-1:0] HONE = HW'(1);
  localparam logic [GW-1:0] GMAX = GW'(RELEASE_CYC);

  filtro_estado_t estado_q, estado_d;
  logic [3:0]     cand_q, cand_d;
  logic [HW-1:0]  held_q, held_d, held_inc;
  logic [GW-1:0]  gap_q, gap_d, gap_inc;
  logic           evento_q, evento_d;
  logic [3:0]     codigo_q, codigo_d;

  // Saturating increments; counters never wrap.
  assign held_inc = (held_q == HMAX) ? HMAX : held_q + HONE;
  assign gap_inc  = (gap_q == GMAX)  ? GMAX : gap_q + GW'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      estado_q <= REPOSO;
      cand_q   <= K_NONE;
      held_q   <= '0;
      gap_q    <= '0;
      evento_q <= 1'b0;
      codigo_q <= K_NONE;
    end else begin
      estado_q <= estado_d;
      cand_q   <= cand_d;
      held_q   <= held_d;
      gap_q    <= gap_d;
      evento_q <= evento_d;
      codigo_q <= codigo_d;
    end
  end

  always_comb begin
    estado_d = estado_q;
    cand_d   = cand_q;
    held_d   = held_q;
    gap_d    = gap_q;
    evento_d = 1'b0;
    codigo_d = codigo_q;
    case (estado_q)
      REPOSO: begin
        if (boton != K_NONE) begin
          cand_d = boton;
          held_d = HONE;
          gap_d  = '0;
          if (HONE == HMAX) begin
            evento_d = 1'b1;
            codigo_d = boton;
            estado_d = PRESIONADO;
          end else begin
            estado_d = CANDIDATO;
          end
        end
      end
      CANDIDATO: begin
        if (boton == cand_q) begin
          held_d = held_inc;
          gap_d  = '0;
          // Acceptance is confirmed on a cycle that actually shows the
          // candidate, so a short glitch followed by silence counts its
          // gap cycles toward held but never fires on them alone.
          if (held_inc == HMAX) begin
            evento_d = 1'b1;
            codigo_d = cand_q;
            estado_d = PRESIONADO;
          end
        end else if (boton == K_NONE) begin
          held_d = held_inc;
          gap_d  = gap_inc;
          if (gap_inc == GMAX) begin
            held_d   = '0;
            gap_d    = '0;
            estado_d = REPOSO;
          end
        end else begin
          cand_d = boton;
          held_d = HONE;
          gap_d  = '0;
          if (HONE == HMAX) begin
            evento_d = 1'b1;
            codigo_d = boton;
            estado_d = PRESIONADO;
          end
        end
      end
      PRESIONADO: begin
        if (boton == K_NONE) begin
          gap_d = gap_inc;
          if (gap_inc == GMAX) begin
            held_d   = '0;
            gap_d    = '0;
            estado_d = REPOSO;
          end
        end else begin
          gap_d = '0;
        end
      end
      default: estado_d = REPOSO;
    endcase
  end

  assign tecla_evento = evento_q;
  assign tecla_codigo = codigo_q;

endmodule

// File: rtl/entrada_numero.sv
// Keypad number entry: filters scanner codes into key events and
// accumulates decimal digits into a BCD number, delivered on a
// valid/ready handshake when enter ('D') is pressed.
// Optional: define ENTRADA_NUMERO_BORRAR_EN to make 0xA a backspace.
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   boton         : scanner code (0x0-0x9, 0xA-0xD, 0xE '*', 0xF none)
//   tecla_evento  : one-cycle pulse per accepted press
//   tecla_codigo  : code of last accepted press
//   num_if        : number delivery channel (master side)
module entrada_numero
  import teclado_pkg::*;
#(
  parameter int DEBOUNCE_CYC = 1000,
  parameter int RELEASE_CYC  = 64,
  parameter int N_DIGITS     = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] boton,
  output logic       tecla_evento,
  output logic [3:0] tecla_codigo,
  entrada_numero_if.master num_if
);

  localparam int NUM_W = 4 * N_DIGITS;
  localparam int NW    = $clog2(N_DIGITS + 1);
  localparam logic [NW-1:0] NMAX = NW'(N_DIGITS);

  antirrebote_tecla #(
    .DEBOUNCE_CYC (DEBOUNCE_CYC),
    .RELEASE_CYC  (RELEASE_CYC)
  ) u_filtro (
    .clk          (clk),
    .rst          (rst),
    .boton        (boton),
    .tecla_evento (tecla_evento),
    .tecla_codigo (tecla_codigo)
  );

  acum_estado_t     estado_q, estado_d;
  logic [NUM_W-1:0] numero_q, numero_d;
  logic [NW-1:0]    n_q, n_d;
  logic             valid_q, valid_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      estado_q <= EDITANDO;
      numero_q <= '0;
      n_q      <= '0;
      valid_q  <= 1'b0;
    end else begin
      estado_q <= estado_d;
      numero_q <= numero_d;
      n_q      <= n_d;
      valid_q  <= valid_d;
    end
  end

  always_comb begin
    estado_d = estado_q;
    numero_d = numero_q;
    n_d      = n_q;
    valid_d  = valid_q;
    case (estado_q)
      EDITANDO: begin
        if (tecla_evento) begin
          if (tecla_codigo <= 4'd9) begin
            // Full buffer: extra digits are dropped, not shifted out.
            if (n_q < NMAX) begin
              numero_d = (numero_q << 4) | NUM_W'(tecla_codigo);
              n_d      = n_q + NW'(1);
            end
          end else if (tecla_codigo == K_STAR) begin
            numero_d = '0;
            n_d      = '0;
          end else if (tecla_codigo == K_ENTER) begin
            if (n_q != '0) begin
              valid_d  = 1'b1;
              estado_d = ENTREGANDO;
            end
`ifdef ENTRADA_NUMERO_BORRAR_EN
          end else if (tecla_codigo == K_BACK) begin
            if (n_q != '0) begin
              numero_d = numero_q >> 4;
              n_d      = n_q - NW'(1);
            end
`endif
          end
        end
      end
      ENTREGANDO: begin
        // Key events are ignored here, including one coinciding with
        // the handshake.
        if (valid_q && num_if.numero_ready) begin
          valid_d  = 1'b0;
          numero_d = '0;
          n_d      = '0;
          estado_d = EDITANDO;
        end
      end
      default: estado_d = EDITANDO;
    endcase
  end

  assign num_if.numero       = numero_q;
  assign num_if.n_digitos    = n_q;
  assign num_if.numero_valid = valid_q;

endmodule

// File: doc/entrada_numero.md
Name: entrada_numero

Overview:
- Sits directly downstream of the 4x4 keypad column scanner and consumes its per-cycle 4-bit key code, where 0xF means no key.
- Filters the intermittent scanned code into clean single-shot key events, with debounce and release detection.
- Accumulates decimal digits into a BCD number and delivers it on a valid/ready handshake when the enter key ('D') is pressed.

Parameters:
- DEBOUNCE_CYC, 1000: consecutive cycles a candidate key must be held (gaps allowed, see Behaviour) before a press is accepted; minimum 1.
- RELEASE_CYC, 64: consecutive 0xF cycles that mean "released"; must be ≥ 4*SCAN_DIV+1 of the scanner.
- N_DIGITS, 3: maximum BCD digits held; minimum 1.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- boton  in  4  scanner key code: 0x0-0x9 digits, 0xA-0xD letters, 0xE '*', 0xF none.
- tecla_evento  out  1  one-cycle pulse per accepted press.
- tecla_codigo  out  4  code of the last accepted press; valid when tecla_evento=1.
- numero  out  4*N_DIGITS  BCD value, least significant digit in [3:0].
- n_digitos  out  $clog2(N_DIGITS+1)  number of digits currently entered.
- numero_valid  out  1  numero is committed and waiting for the consumer.
- numero_ready  in  1  consumer accepts numero.

Behaviour:
- Reset (rst=1 at a clock edge):
  - All outputs go to 0, except tecla_codigo which goes to 0xF.
  - Both FSMs return to their initial state and all counters clear.
  - Reset mid-press or mid-handshake discards everything, including a pending numero.
- Filter FSM states: REPOSO, CANDIDATO, PRESIONADO.
  - REPOSO:
    - boton≠0xF → latch cand=boton, held counter=1, gap counter=0, go to CANDIDATO.
  - CANDIDATO, each cycle:
    - boton==cand → held++, gap=0.
    - boton==0xF → held++, gap++. If gap reaches RELEASE_CYC, go to REPOSO with no event.
    - boton is another non-0xF code → restart: cand=boton, held=1, gap=0.
    - held reaches DEBOUNCE_CYC → next cycle tecla_evento=1, tecla_codigo=cand, go to PRESIONADO.
  - PRESIONADO:
    - Exactly one event per press; no auto-repeat.
    - gap counts consecutive 0xF cycles; any non-0xF code resets gap.
    - gap==RELEASE_CYC → go to REPOSO.
    - A different code while pressed does not create a new event.
  - Counter widths come from $clog2(max+1) and saturate; they never wrap.
- Accumulator FSM states: EDITANDO, ENTREGANDO. Events are applied in the cycle after tecla_evento, so numero and n_digitos change 1 cycle after the pulse.
  - EDITANDO:
    - digit 0-9 with n_digitos<N_DIGITS → numero=(numero<<4)|digit, n_digitos++.
    - digit with n_digitos==N_DIGITS → ignored (no wrap, no overwrite).
    - 0xE '*' → numero=0, n_digitos=0.
    - 0xD enter with n_digitos>0 → numero_valid=1, go to ENTREGANDO.
    - 0xD enter with n_digitos==0 → ignored.
    - 0xA-0xC → ignored (but see optional feature for 0xA).
  - ENTREGANDO:
    - numero, n_digitos and numero_valid are held stable.
    - All key events are ignored.
    - On a cycle with numero_valid & numero_ready: next cycle numero_valid=0, numero=0, n_digitos=0, go to EDITANDO.
    - numero_ready high while not valid has no effect.
- Key event and handshake completion in the same cycle: the event is dropped.
- '#' shares code 0xF with "none" and therefore can never be entered; this is documented behaviour.

Optional Feature:
- Macro ENTRADA_NUMERO_BORRAR_EN.
- Defined: key 0xA in EDITANDO acts as backspace. numero=numero>>4 and n_digitos-- when n_digitos>0; no-op when n_digitos==0.
- Undefined: 0xA is ignored like 0xB/0xC.

Decomposition:
- Package teclado_pkg holds:
  - Key code constants: K_NONE=4'hF, K_STAR=4'hE, K_ENTER=4'hD, K_BACK=4'hA.
  - Enum filtro_estado_t {REPOSO, CANDIDATO, PRESIONADO}.
  - Enum acum_estado_t {EDITANDO, ENTREGANDO}.
- One sub-module, antirrebote_tecla: the filter FSM with parameters DEBOUNCE_CYC and RELEASE_CYC, outputs tecla_evento/tecla_codigo. The accumulator stays in the top module.

Test Plan (DEBOUNCE_CYC=8, RELEASE_CYC=6, N_DIGITS=3):
- boton=0x5 one cycle in every 4 (0xF otherwise) for 40 cycles, then 0xF for 10 cycles → exactly one tecla_evento with tecla_codigo=0x5; numero=0x005, n_digitos=1.
- Press 1, 2, 3, 4 then D with numero_ready=0 for 5 cycles → numero=0x123, n_digitos=3; numero_valid stays high and stable. Raise ready → valid drops next cycle, numero=0, n_digitos=0.
- Glitch: boton=0x7 for 3 cycles, then 0xF for 6 cycles → no event; filter back in REPOSO.
- Press 9, 8, then '*', then D → after '*' numero=0 and n_digitos=0; D ignored, numero_valid stays 0.
- Assert rst while in ENTREGANDO with numero=0x042 → next cycle numero_valid=0, numero=0, tecla_codigo=0xF.
- With ENTRADA_NUMERO_BORRAR_EN: press 4, 2, A → numero=0x004, n_digitos=1. Without the macro → numero=0x042, n_digitos=2.
